// File: rtl/usb_uart_fifo_pkg.sv
// Shared widths, default depth and payload types for the USB CDC buffer pair.
package usb_uart_fifo_pkg;

    localparam int unsigned USB_UART_DATA_W     = 8;
    localparam int unsigned USB_UART_RX_W       = 9;
    localparam int unsigned USB_UART_DEPTH_LOG2 = 4;

    // Occupancy count for the default depth; one extra bit represents "full".
    typedef logic [USB_UART_DEPTH_LOG2:0] usb_uart_level_t;

    // RX entry as stored in the FIFO: error flag above the data byte.
    typedef struct packed {
        logic                       err;
        logic [USB_UART_DATA_W-1:0] data;
    } usb_uart_rx_entry_t;

endpackage

// File: rtl/usb_uart_sync_fifo.sv
// Single-clock circular FIFO with show-ahead head, flush and overflow pulse.
module usb_uart_sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_48mhz,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      rdata_c,
    output logic                  empty_c,
    output logic                  full_c,
    output logic [DEPTH_LOG2:0]   level_c,
    output logic                  ovf_c
);

    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Status comes only from registered pointers; flush overrides both ports.
    always_comb begin
        level_c = wr_ptr - rd_ptr;
        empty_c = (level_c == '0);
        full_c  = (level_c == PTR_W'(DEPTH));
        do_push = push & ~full_c & ~flush;
        do_pop  = pop & ~empty_c & ~flush;
        ovf_c   = push & full_c;
        rdata_c = empty_c ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
    end

    // Pointer update; the spare MSB lets pointers wrap naturally.
    always_ff @(posedge clk_48mhz or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk_48mhz) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
    end

endmodule

// File: rtl/usb_uart_fifo.sv
// TX/RX buffer pair between the system bus and the usb_uart CDC engine.
module usb_uart_fifo
    import usb_uart_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2    = USB_UART_DEPTH_LOG2,
    parameter int unsigned RX_IRQ_THRESH = 1
) (
    input  logic                       clk_48mhz,
    input  logic                       rstn,
    output logic                       tx_empty,
    input  logic                       tx_read,
    output logic [USB_UART_DATA_W-1:0] tx_fifo_rdata,
    output logic                       rx_full,
    input  logic                       rx_write,
    input  logic [USB_UART_DATA_W-1:0] rx_fifo_wdata,
    input  logic                       rx_err,
    input  logic                       sys_tx_we,
    input  logic [USB_UART_DATA_W-1:0] sys_tx_wdata,
    output logic                       sys_tx_full,
    input  logic                       sys_rx_re,
    output logic [USB_UART_RX_W-1:0]   sys_rx_rdata,
    output logic                       sys_rx_empty,
    output logic [DEPTH_LOG2:0]        sys_tx_level,
    output logic [DEPTH_LOG2:0]        sys_rx_level,
    input  logic                       sys_flush,
    input  logic                       sys_clr_ovf,
    output logic                       tx_ovf,
    output logic                       rx_ovf,
    output logic                       irq
);

    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    usb_uart_rx_entry_t rx_entry;
    logic               tx_ovf_c;
    logic               rx_ovf_c;

    // Pack the engine's byte and error flag into one RX entry.
    always_comb begin
        rx_entry      = '0;
        rx_entry.err  = rx_err;
        rx_entry.data = rx_fifo_wdata;
    end

    usb_uart_sync_fifo #(
        .WIDTH      (USB_UART_DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk_48mhz (clk_48mhz),
        .rstn      (rstn),
        .push      (sys_tx_we),
        .wdata     (sys_tx_wdata),
        .pop       (tx_read),
        .flush     (sys_flush),
        .rdata_c   (tx_fifo_rdata),
        .empty_c   (tx_empty),
        .full_c    (sys_tx_full),
        .level_c   (sys_tx_level),
        .ovf_c     (tx_ovf_c)
    );

    usb_uart_sync_fifo #(
        .WIDTH      (USB_UART_RX_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk_48mhz (clk_48mhz),
        .rstn      (rstn),
        .push      (rx_write),
        .wdata     (rx_entry),
        .pop       (sys_rx_re),
        .flush     (sys_flush),
        .rdata_c   (sys_rx_rdata),
        .empty_c   (sys_rx_empty),
        .full_c    (rx_full),
        .level_c   (sys_rx_level),
        .ovf_c     (rx_ovf_c)
    );

    // Sticky overflow flags; a new overflow beats a same-cycle clear.
    always_ff @(posedge clk_48mhz or negedge rstn) begin
        if (!rstn) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            tx_ovf <= tx_ovf_c | (tx_ovf & ~sys_clr_ovf);
            rx_ovf <= rx_ovf_c | (rx_ovf & ~sys_clr_ovf);
        end
    end

    // Interrupt registered from the current level and flag state.
    always_ff @(posedge clk_48mhz or negedge rstn) begin
        if (!rstn) begin
            irq <= 1'b0;
        end else begin
            irq <= (sys_rx_level >= LVL_W'(RX_IRQ_THRESH)) | rx_ovf | tx_ovf;
        end
    end

endmodule

// File: tb/tb_usb_uart_fifo.sv
// Directed bench for usb_uart_fifo with hand-computed expectations.
module tb_usb_uart_fifo;

    logic       clk_48mhz = 1'b0;
    logic       rstn;
    logic       tx_empty;
    logic       tx_read;
    logic [7:0] tx_fifo_rdata;
    logic       rx_full;
    logic       rx_write;
    logic [7:0] rx_fifo_wdata;
    logic       rx_err;
    logic       sys_tx_we;
    logic [7:0] sys_tx_wdata;
    logic       sys_tx_full;
    logic       sys_rx_re;
    logic [8:0] sys_rx_rdata;
    logic       sys_rx_empty;
    logic [4:0] sys_tx_level;
    logic [4:0] sys_rx_level;
    logic       sys_flush;
    logic       sys_clr_ovf;
    logic       tx_ovf;
    logic       rx_ovf;
    logic       irq;

    int checks = 0;
    int errors = 0;

    always #5 clk_48mhz = ~clk_48mhz;

    usb_uart_fifo #(
        .DEPTH_LOG2    (4),
        .RX_IRQ_THRESH (1)
    ) dut (
        .clk_48mhz     (clk_48mhz),
        .rstn          (rstn),
        .tx_empty      (tx_empty),
        .tx_read       (tx_read),
        .tx_fifo_rdata (tx_fifo_rdata),
        .rx_full       (rx_full),
        .rx_write      (rx_write),
        .rx_fifo_wdata (rx_fifo_wdata),
        .rx_err        (rx_err),
        .sys_tx_we     (sys_tx_we),
        .sys_tx_wdata  (sys_tx_wdata),
        .sys_tx_full   (sys_tx_full),
        .sys_rx_re     (sys_rx_re),
        .sys_rx_rdata  (sys_rx_rdata),
        .sys_rx_empty  (sys_rx_empty),
        .sys_tx_level  (sys_tx_level),
        .sys_rx_level  (sys_rx_level),
        .sys_flush     (sys_flush),
        .sys_clr_ovf   (sys_clr_ovf),
        .tx_ovf        (tx_ovf),
        .rx_ovf        (rx_ovf),
        .irq           (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_48mhz);
        #1;
    endtask

    function automatic logic [8:0] exp_rx(input int idx);
        logic [31:0] v;
        v = 32'(idx);
        return {v[0], 8'(32'hA0 + v)};
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_tx_empty"}, 32'(tx_empty), 32'd1);
        chk({tag, "_rx_empty"}, 32'(sys_rx_empty), 32'd1);
        chk({tag, "_rx_full"}, 32'(rx_full), 32'd0);
        chk({tag, "_tx_full"}, 32'(sys_tx_full), 32'd0);
        chk({tag, "_tx_level"}, 32'(sys_tx_level), 32'd0);
        chk({tag, "_rx_level"}, 32'(sys_rx_level), 32'd0);
        chk({tag, "_tx_rdata"}, 32'(tx_fifo_rdata), 32'd0);
        chk({tag, "_rx_rdata"}, 32'(sys_rx_rdata), 32'd0);
        chk({tag, "_tx_ovf"}, 32'(tx_ovf), 32'd0);
        chk({tag, "_rx_ovf"}, 32'(rx_ovf), 32'd0);
        chk({tag, "_irq"}, 32'(irq), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; tx_read = 1'b0; rx_write = 1'b0; rx_fifo_wdata = '0; rx_err = 1'b0;
        sys_tx_we = 1'b0; sys_tx_wdata = '0; sys_rx_re = 1'b0;
        sys_flush = 1'b0; sys_clr_ovf = 1'b0;

        // Reset values
        repeat (2) @(posedge clk_48mhz);
        #1;
        chk_reset_state("reset");
        rstn = 1'b1;
        tick();

        // TX write 0x41..0x43, then engine pops back-to-back
        sys_tx_we = 1'b1; sys_tx_wdata = 8'h41;
        tick();
        chk("tx_first_empty", 32'(tx_empty), 32'd0);
        chk("tx_first_head", 32'(tx_fifo_rdata), 32'h41);
        chk("tx_first_level", 32'(sys_tx_level), 32'd1);
        sys_tx_wdata = 8'h42; tick();
        sys_tx_wdata = 8'h43; tick();
        sys_tx_we = 1'b0;
        chk("tx_level3", 32'(sys_tx_level), 32'd3);
        tx_read = 1'b1;
        tick(); chk("tx_pop1", 32'(tx_fifo_rdata), 32'h42);
        tick(); chk("tx_pop2", 32'(tx_fifo_rdata), 32'h43);
        tick();
        chk("tx_pop3_empty", 32'(tx_empty), 32'd1);
        chk("tx_pop3_rdata", 32'(tx_fifo_rdata), 32'd0);
        tick();
        tx_read = 1'b0;
        chk("tx_pop_empty_level", 32'(sys_tx_level), 32'd0);
        chk("tx_pop_empty_noovf", 32'(tx_ovf), 32'd0);

        // Fill TX to 16, overflow on the 17th write
        sys_tx_we = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sys_tx_wdata = 8'(8'h10 + i);
            tick();
            if (i == 14) chk("tx_not_full_15", 32'(sys_tx_full), 32'd0);
        end
        chk("tx_full", 32'(sys_tx_full), 32'd1);
        chk("tx_level16", 32'(sys_tx_level), 32'd16);
        sys_tx_wdata = 8'hEE;
        tick();
        sys_tx_we = 1'b0;
        chk("tx_ovf_set", 32'(tx_ovf), 32'd1);
        chk("tx_ovf_irq_lag", 32'(irq), 32'd0);
        chk("tx_ovf_level", 32'(sys_tx_level), 32'd16);
        chk("tx_ovf_head", 32'(tx_fifo_rdata), 32'h10);
        tick();
        chk("tx_ovf_irq", 32'(irq), 32'd1);
        sys_clr_ovf = 1'b1;
        tick();
        sys_clr_ovf = 1'b0;
        chk("tx_ovf_clr", 32'(tx_ovf), 32'd0);
        chk("tx_ovf_clr_irq_lag", 32'(irq), 32'd1);
        tick();
        chk("tx_ovf_clr_irq", 32'(irq), 32'd0);
        sys_flush = 1'b1;
        tick();
        sys_flush = 1'b0;
        chk("tx_flush_level", 32'(sys_tx_level), 32'd0);

        // RX single entry with error flag, irq timing
        rx_write = 1'b1; rx_fifo_wdata = 8'h55; rx_err = 1'b1;
        tick();
        rx_write = 1'b0; rx_err = 1'b0;
        chk("rx_head_err", 32'(sys_rx_rdata), 32'h155);
        chk("rx_level1", 32'(sys_rx_level), 32'd1);
        chk("rx_irq_n", 32'(irq), 32'd0);
        tick();
        chk("rx_irq_n1", 32'(irq), 32'd1);
        sys_rx_re = 1'b1;
        tick();
        sys_rx_re = 1'b0;
        chk("rx_pop_empty", 32'(sys_rx_empty), 32'd1);
        chk("rx_pop_rdata", 32'(sys_rx_rdata), 32'd0);
        chk("rx_pop_irq_lag", 32'(irq), 32'd1);
        tick();
        chk("rx_pop_irq", 32'(irq), 32'd0);

        // RX overflow, set beats clear, flush keeps flag
        rx_write = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_fifo_wdata = 8'(i);
            tick();
        end
        chk("rx_full", 32'(rx_full), 32'd1);
        chk("rx_full_ovf0", 32'(rx_ovf), 32'd0);
        tick();
        chk("rx_ovf_set", 32'(rx_ovf), 32'd1);
        chk("rx_ovf_level", 32'(sys_rx_level), 32'd16);
        sys_clr_ovf = 1'b1;
        tick();
        rx_write = 1'b0;
        chk("rx_ovf_set_wins", 32'(rx_ovf), 32'd1);
        sys_clr_ovf = 1'b0; sys_flush = 1'b1;
        tick();
        sys_flush = 1'b0;
        chk("rx_flush_level", 32'(sys_rx_level), 32'd0);
        chk("rx_flush_keeps_ovf", 32'(rx_ovf), 32'd1);
        sys_clr_ovf = 1'b1;
        tick();
        sys_clr_ovf = 1'b0;
        chk("rx_ovf_clr", 32'(rx_ovf), 32'd0);

        // Steady push+pop at level 3 across pointer wrap
        rx_write = 1'b1;
        for (int j = 0; j < 3; j++) begin
            {rx_err, rx_fifo_wdata} = exp_rx(j);
            tick();
        end
        chk("rx_wrap_start_level", 32'(sys_rx_level), 32'd3);
        chk("rx_wrap_start_head", 32'(sys_rx_rdata), 32'(exp_rx(0)));
        sys_rx_re = 1'b1;
        for (int k = 0; k < 40; k++) begin
            {rx_err, rx_fifo_wdata} = exp_rx(k + 3);
            tick();
            chk("rx_wrap_level", 32'(sys_rx_level), 32'd3);
            chk("rx_wrap_head", 32'(sys_rx_rdata), 32'(exp_rx(k + 1)));
        end
        sys_rx_re = 1'b0;
        {rx_err, rx_fifo_wdata} = exp_rx(43); tick();
        {rx_err, rx_fifo_wdata} = exp_rx(44); tick();
        rx_write = 1'b0; rx_err = 1'b0;
        chk("rx_level5", 32'(sys_rx_level), 32'd5);
        chk("rx_level5_head", 32'(sys_rx_rdata), 32'(exp_rx(40)));

        // Flush at 5/5 with coincident pushes
        sys_tx_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sys_tx_wdata = 8'(8'h60 + i);
            tick();
        end
        chk("tx_level5", 32'(sys_tx_level), 32'd5);
        sys_flush = 1'b1; rx_write = 1'b1; rx_fifo_wdata = 8'h99; sys_tx_wdata = 8'h99;
        tick();
        sys_flush = 1'b0; rx_write = 1'b0; sys_tx_we = 1'b0;
        chk("flush_tx_level", 32'(sys_tx_level), 32'd0);
        chk("flush_rx_level", 32'(sys_rx_level), 32'd0);
        chk("flush_tx_empty", 32'(tx_empty), 32'd1);
        chk("flush_rx_empty", 32'(sys_rx_empty), 32'd1);
        chk("flush_tx_ovf", 32'(tx_ovf), 32'd0);
        chk("flush_rx_ovf", 32'(rx_ovf), 32'd0);
        tick();
        chk("flush_tx_stays", 32'(sys_tx_level), 32'd0);
        chk("flush_rx_stays", 32'(sys_rx_level), 32'd0);

        // Asynchronous reset at level 7
        sys_tx_we = 1'b1; rx_write = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sys_tx_wdata = 8'(8'h30 + i);
            rx_fifo_wdata = 8'(8'h70 + i);
            tick();
        end
        chk("pre_rst_tx_level", 32'(sys_tx_level), 32'd7);
        chk("pre_rst_rx_level", 32'(sys_rx_level), 32'd7);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_state("async_rst");
        sys_tx_we = 1'b0; rx_write = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        sys_tx_we = 1'b1; sys_tx_wdata = 8'h77;
        tick();
        sys_tx_we = 1'b0;
        chk("post_rst_level", 32'(sys_tx_level), 32'd1);
        chk("post_rst_head", 32'(tx_fifo_rdata), 32'h77);
        chk("post_rst_rx_level", 32'(sys_rx_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
